// File: rtl/ram_pkg.sv
// Shared definitions for the clearable RAM: FSM encoding and read-during-write modes.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_clr_if.sv
// User-side access bus of the clearable RAM, plus a debug view of the FSM state.
interface ram_clr_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 14
);
  import ram_pkg::*;

  // Accesses are single-cycle requests with no stall: load/read_en/clear are
  // sampled at the rising edge only while busy=0; out_valid pulses one cycle
  // after an accepted read_en, and out holds its value otherwise.
  logic [WIDTH-1:0]  in_value;
  logic              load;
  logic              read_en;
  logic [ADDR_W-1:0] address;
  logic              clear;
  logic              busy;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  state_t            dbg_state;

  modport master (
    output in_value, load, read_en, address, clear,
    input  busy, out, out_valid, dbg_state
  );

  modport slave (
    input  in_value, load, read_en, address, clear,
    output busy, out, out_valid, dbg_state
  );

endinterface

// File: rtl/ram_core.sv
// Single-port array with one write port and a registered read; READ_MODE picks
// old or new data when a read and write hit the same word in one cycle.
module ram_core
  import ram_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 14,
  parameter int READ_MODE = RD_FIRST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      if (READ_MODE == WR_FIRST && we_i) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_clr.sv
// Clearable RAM: sweeps zeros through every word after reset or on request,
// and arbitrates the single write port between the sweep and user accesses.
module ram_clr
  import ram_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 14,
  parameter int READ_MODE = RD_FIRST
) (
  input  logic     clk,
  input  logic     reset,
  ram_clr_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= mem_re;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = bus.address;
    mem_wdata = bus.in_value;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        // Terminal compare rather than relying on wrap, so the sweep is exactly DEPTH writes.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          mem_we = bus.load;
          mem_re = bus.read_en;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  ram_core #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .READ_MODE (READ_MODE)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (bus.out)
  );

  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.out_valid = valid_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ram_clr.sv
// Bench for ram_clr: one read-first and one write-first instance driven in lockstep.
module tb_ram_clr;
  import ram_pkg::*;

  localparam int W     = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  ram_clr_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();
  ram_clr_if #(.WIDTH(W), .ADDR_W(AW)) bus1 ();

  ram_clr #(.WIDTH(W), .ADDR_W(AW), .READ_MODE(RD_FIRST)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  ram_clr #(.WIDTH(W), .ADDR_W(AW), .READ_MODE(WR_FIRST)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mem_m [DEPTH];
  logic [W-1:0] last0, last1;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  typedef struct {
    logic         ld;
    logic         rd;
    logic [AW-1:0] addr;
    logic [W-1:0] data;
    logic         ev;
    logic [W-1:0] o0;
    logic [W-1:0] o1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic rd, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic clr);
    bus0.load = ld;  bus1.load = ld;
    bus0.read_en = rd;  bus1.read_en = rd;
    bus0.address = a;  bus1.address = a;
    bus0.in_value = d;  bus1.in_value = d;
    bus0.clear = clr;  bus1.clear = clr;
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // One IDLE cycle: drive at negedge, predict, check at the next negedge.
  task automatic step(input logic ld, input logic rd, input logic [AW-1:0] a, input logic [W-1:0] d);
    drive(ld, rd, a, d, 1'b0);
    if (rd) begin
      exp_q0.push_back(mem_m[a]);
      exp_q1.push_back(ld ? d : mem_m[a]);
    end
    if (ld) mem_m[a] = d;
    @(negedge clk);
    check("out_valid0", 32'(bus0.out_valid), 32'(rd));
    check("out_valid1", 32'(bus1.out_valid), 32'(rd));
    if (rd && exp_q0.size() > 0 && exp_q1.size() > 0) begin
      last0 = exp_q0.pop_front();
      last1 = exp_q1.pop_front();
    end
    check("out0", 32'(bus0.out), 32'(last0));
    check("out1", 32'(bus1.out), 32'(last1));
  endtask

  // Count negedge samples with busy=1 while throwing random ignored accesses at the DUT.
  task automatic count_busy(output int n);
    n = 0;
    while (bus0.busy && n < 100) begin
      n++;
      check("busy1_in_sweep", 32'(bus1.busy), 32'd1);
      check("valid0_in_sweep", 32'(bus0.out_valid), 32'd0);
      check("valid1_in_sweep", 32'(bus1.out_valid), 32'd0);
      check("out0_held", 32'(bus0.out), 32'(last0));
      check("out1_held", 32'(bus1.out), 32'(last1));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    check("busy1_after_sweep", 32'(bus1.busy), 32'd0);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, AW'(a), '0);
    check("last_zero_read", 32'(bus0.out), 32'h0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 4'd3,  16'hBEEF, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 4'd3,  16'h0000, 1'b1, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'hBEEF, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 4'd5,  16'hAAAA, 1'b0, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b1, 4'd5,  16'h1234, 1'b1, 16'hAAAA, 16'h1234};
    vecs[5] = '{1'b0, 1'b1, 4'd5,  16'h0000, 1'b1, 16'h1234, 16'h1234};
    vecs[6] = '{1'b1, 1'b0, 4'd15, 16'hCAFE, 1'b0, 16'h1234, 16'h1234};
    vecs[7] = '{1'b0, 1'b1, 4'd15, 16'h0000, 1'b1, 16'hCAFE, 16'hCAFE};
    vecs[8] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'hCAFE, 16'hCAFE};

    // reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #2;
    check("rst_out0", 32'(bus0.out), 32'h0);
    check("rst_out1", 32'(bus1.out), 32'h0);
    check("rst_valid0", 32'(bus0.out_valid), 32'h0);
    check("rst_busy0", 32'(bus0.busy), 32'h1);
    check("rst_state0", 32'(bus0.dbg_state), 32'(ST_CLEAR));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last0 = '0;
    last1 = '0;
    model_zero();
    count_busy(n);
    check("reset_sweep_len", 32'(n), 32'd16);
    check("idle_state0", 32'(bus0.dbg_state), 32'(ST_IDLE));
    read_all_zero();

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].ld, vecs[i].rd, vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d_valid", i), 32'(bus0.out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_out0", i), 32'(bus0.out), 32'(vecs[i].o0));
      check($sformatf("vec%0d_out1", i), 32'(bus1.out), 32'(vecs[i].o1));
    end

    // randomized traffic against the model
    repeat (300) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
           W'($urandom_range(0, 65535)));
    end

    // fill, then clear together with a load and a read
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, AW'(a), W'(a + 1));
    step(1'b0, 1'b1, 4'd7, '0);
    check("fill_read7", 32'(bus0.out), 32'h0008);
    drive(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1);
    @(negedge clk);
    check("clear_drops_read0", 32'(bus0.out_valid), 32'h0);
    check("clear_drops_read1", 32'(bus1.out_valid), 32'h0);
    count_busy(n);
    check("clear_sweep_len", 32'(n), 32'd16);
    model_zero();
    read_all_zero();

    // reset while the sweep counter is at 9
    step(1'b1, 1'b0, 4'd2, 16'h5555);
    step(1'b0, 1'b1, 4'd2, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (9) @(negedge clk);
    check("mid_sweep_busy", 32'(bus0.busy), 32'h1);
    check("mid_sweep_out_held", 32'(bus0.out), 32'h5555);
    reset = 1'b1;
    #1;
    check("rst_mid_out0", 32'(bus0.out), 32'h0);
    check("rst_mid_out1", 32'(bus1.out), 32'h0);
    check("rst_mid_valid0", 32'(bus0.out_valid), 32'h0);
    check("rst_mid_busy0", 32'(bus0.busy), 32'h1);
    last0 = '0;
    last1 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    check("restart_sweep_len", 32'(n), 32'd16);
    model_zero();

    // reset while a read result is on out
    step(1'b1, 1'b0, 4'd4, 16'h0F0F);
    drive(1'b0, 1'b1, 4'd4, '0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_valid0", 32'(bus0.out_valid), 32'h1);
    check("pre_rst_out0", 32'(bus0.out), 32'h0F0F);
    reset = 1'b1;
    #1;
    check("rst_read_valid0", 32'(bus0.out_valid), 32'h0);
    check("rst_read_valid1", 32'(bus1.out_valid), 32'h0);
    check("rst_read_out0", 32'(bus0.out), 32'h0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    last0 = '0;
    last1 = '0;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    check("post_read_rst_sweep_len", 32'(n), 32'd16);
    model_zero();
    step(1'b0, 1'b1, 4'd4, '0);
    check("addr4_cleared", 32'(bus0.out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
